// File: rtl/ro_puf_pkg.sv
// Shared types and constants for the ring-oscillator PUF controller.
package ro_puf_pkg;

    localparam int unsigned DefSelW = 4;
    localparam int unsigned DefCntW = 16;
    localparam int unsigned DefWinW = 12;

    // Fibonacci taps at bits 7, 5, 4 and 3.
    localparam logic [7:0] LfsrTaps     = 8'hB8;
    localparam logic [7:0] LfsrZeroSeed = 8'h01;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StRun,
        StSettle,
        StCompare,
        StDone
    } state_e;

    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], ^(s & LfsrTaps)};
    endfunction

endpackage

// File: rtl/ro_puf_lfsr8.sv
// Challenge LFSR with registered ring-oscillator pair selection.
module ro_puf_lfsr8
    import ro_puf_pkg::*;
#(
    parameter int unsigned SelW = DefSelW
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            load_i,
    input  logic [7:0]      seed_i,
    input  logic            advance_i,
    output logic [SelW-1:0] sel_a_o,
    output logic [SelW-1:0] sel_b_o
);

    localparam int unsigned ExtW = (2 * SelW > 8) ? 2 * SelW : 8;

    logic [7:0]      lfsr_q, lfsr_d;
    logic [SelW-1:0] sel_a_q, sel_b_q;
    logic [SelW-1:0] pair_a, pair_b;
    logic [ExtW-1:0] lfsr_ext;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load_i) begin
            lfsr_d = (seed_i == 8'h00) ? LfsrZeroSeed : seed_i;
        end else if (advance_i) begin
            lfsr_d = lfsr_step(lfsr_q);
        end
    end

    // Pair is taken from the next LFSR value so the selects change together with it.
    always_comb begin
        lfsr_ext = ExtW'(lfsr_d);
        pair_a   = lfsr_ext[SelW-1:0];
        pair_b   = lfsr_ext[2*SelW-1:SelW];
        if (pair_b == pair_a) begin
            pair_b = pair_a ^ SelW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr_q  <= LfsrZeroSeed;
            sel_a_q <= '0;
            sel_b_q <= '0;
        end else begin
            lfsr_q <= lfsr_d;
            if (load_i || advance_i) begin
                sel_a_q <= pair_a;
                sel_b_q <= pair_b;
            end
        end
    end

    assign sel_a_o = sel_a_q;
    assign sel_b_o = sel_b_q;

endmodule

// File: rtl/ro_puf_ctrl.sv
// Ring-oscillator PUF sequencer: clear, run, settle and compare one RO pair per response bit.
// Define RO_PUF_MAJ_VOTE_EN to evaluate each pair three times and keep the majority result.
module ro_puf_ctrl
    import ro_puf_pkg::*;
#(
    parameter int unsigned SEL_W     = DefSelW,
    parameter int unsigned CNT_W     = DefCntW,
    parameter int unsigned WIN_W     = DefWinW,
    parameter int unsigned RESP_BITS = 8,
    parameter int unsigned SETTLE    = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [7:0]           challenge_i,
    input  logic [WIN_W-1:0]     window_len_i,
    input  logic [CNT_W-1:0]     cnt_a_i,
    input  logic [CNT_W-1:0]     cnt_b_i,
    output logic                 ro_en_o,
    output logic                 cnt_clr_o,
    output logic [SEL_W-1:0]     sel_a_o,
    output logic [SEL_W-1:0]     sel_b_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [RESP_BITS-1:0] response_o
);

    localparam int unsigned SetW = $clog2(SETTLE + 1);
    localparam int unsigned TmrW = (WIN_W > SetW) ? WIN_W : SetW;
    localparam int unsigned IdxW = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(RESP_BITS - 1);

    state_e               state_q, state_d;
    logic [WIN_W-1:0]     win_q, win_d;
    logic [TmrW-1:0]      timer_q, timer_d;
    logic [IdxW-1:0]      idx_q, idx_d;
    logic [RESP_BITS-1:0] shadow_q, shadow_d;
    logic [RESP_BITS-1:0] response_q, response_d;
    logic                 ro_en_q, cnt_clr_q, busy_q, done_q;
    logic                 lfsr_load, lfsr_adv;
    logic                 cmp_bit, bit_ready, bit_val;

    assign cmp_bit = (cnt_a_i > cnt_b_i);

`ifdef RO_PUF_MAJ_VOTE_EN
    logic [1:0] vote_q, vote_d, pass_q, pass_d, vote_sum;

    // Three passes per pair; the bit is ready on the third compare.
    always_comb begin
        vote_sum  = vote_q + {1'b0, cmp_bit};
        bit_ready = (pass_q == 2'd2);
        bit_val   = vote_sum[1];
        vote_d    = vote_q;
        pass_d    = pass_q;
        if (state_q == StCompare) begin
            if (bit_ready) begin
                vote_d = '0;
                pass_d = '0;
            end else begin
                vote_d = vote_sum;
                pass_d = pass_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vote_q <= '0;
            pass_q <= '0;
        end else begin
            vote_q <= vote_d;
            pass_q <= pass_d;
        end
    end
`else
    always_comb begin
        bit_ready = 1'b1;
        bit_val   = cmp_bit;
    end
`endif

    always_comb begin
        state_d    = state_q;
        win_d      = win_q;
        timer_d    = timer_q;
        idx_d      = idx_q;
        shadow_d   = shadow_q;
        response_d = response_q;
        lfsr_load  = 1'b0;
        lfsr_adv   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    win_d     = (window_len_i == '0) ? WIN_W'(1) : window_len_i;
                    lfsr_load = 1'b1;
                    shadow_d  = '0;
                    idx_d     = '0;
                    state_d   = StClear;
                end
            end
            StClear: begin
                timer_d = TmrW'(win_q) - TmrW'(1);
                state_d = StRun;
            end
            StRun: begin
                if (timer_q == '0) begin
                    timer_d = TmrW'(SETTLE - 1);
                    state_d = StSettle;
                end else begin
                    timer_d = timer_q - TmrW'(1);
                end
            end
            StSettle: begin
                if (timer_q == '0) begin
                    state_d = StCompare;
                end else begin
                    timer_d = timer_q - TmrW'(1);
                end
            end
            StCompare: begin
                if (bit_ready) begin
                    shadow_d[idx_q] = bit_val;
                    lfsr_adv        = 1'b1;
                    if (idx_q == LastIdx) begin
                        // Publish now so response is valid in the same cycle as done.
                        response_d = shadow_d;
                        state_d    = StDone;
                    end else begin
                        idx_d   = idx_q + IdxW'(1);
                        state_d = StClear;
                    end
                end else begin
                    state_d = StClear;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            win_q      <= WIN_W'(1);
            timer_q    <= '0;
            idx_q      <= '0;
            shadow_q   <= '0;
            response_q <= '0;
            ro_en_q    <= 1'b0;
            cnt_clr_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            timer_q    <= timer_d;
            idx_q      <= idx_d;
            shadow_q   <= shadow_d;
            response_q <= response_d;
            ro_en_q    <= (state_d == StRun);
            cnt_clr_q  <= (state_d == StClear);
            busy_q     <= (state_d != StIdle);
            done_q     <= (state_d == StDone);
        end
    end

    ro_puf_lfsr8 #(
        .SelW(SEL_W)
    ) u_lfsr (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load_i   (lfsr_load),
        .seed_i   (challenge_i),
        .advance_i(lfsr_adv),
        .sel_a_o  (sel_a_o),
        .sel_b_o  (sel_b_o)
    );

    assign ro_en_o    = ro_en_q;
    assign cnt_clr_o  = cnt_clr_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign response_o = response_q;

endmodule

// File: tb/tb_ro_puf_ctrl.sv
// Self-checking bench for ro_puf_ctrl: directed vector table, abort sequence and random runs.
module tb_ro_puf_ctrl;

    localparam int SelW     = 4;
    localparam int CntW     = 16;
    localparam int WinW     = 12;
    localparam int RespBits = 8;
    localparam int Settle   = 4;
`ifdef RO_PUF_MAJ_VOTE_EN
    localparam int Passes = 3;
`else
    localparam int Passes = 1;
`endif
    localparam int MaxEval  = RespBits * Passes;
    localparam int LatLimit = 5000;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                start = 1'b0;
    logic [7:0]          challenge = '0;
    logic [WinW-1:0]     window_len = '0;
    logic [CntW-1:0]     cnt_a = '0;
    logic [CntW-1:0]     cnt_b = '0;
    logic                ro_en, cnt_clr, busy, done;
    logic [SelW-1:0]     sel_a, sel_b;
    logic [RespBits-1:0] response;

    int errors = 0;
    int checks = 0;

    // Per-evaluation stimulus and observations, indexed by cnt_clr pulse number.
    logic [CntW-1:0] va [MaxEval];
    logic [CntW-1:0] vb [MaxEval];
    logic [SelW-1:0] sel_log_a [MaxEval];
    logic [SelW-1:0] sel_log_b [MaxEval];
    int              ro_cnt [MaxEval];
    int              ev = 0;
    int              unstable = 0;

    typedef struct {
        logic [7:0] ch;
        int         win;
        int         pat;
        int         exp_resp;
        int         exp_lat;
        int         a0;
        int         b0;
        bit         poke;
    } vec_t;

    vec_t vecs [5];

    always #5 clk = ~clk;

    ro_puf_ctrl #(
        .SEL_W    (SelW),
        .CNT_W    (CntW),
        .WIN_W    (WinW),
        .RESP_BITS(RespBits),
        .SETTLE   (Settle)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .challenge_i (challenge),
        .window_len_i(window_len),
        .cnt_a_i     (cnt_a),
        .cnt_b_i     (cnt_b),
        .ro_en_o     (ro_en),
        .cnt_clr_o   (cnt_clr),
        .sel_a_o     (sel_a),
        .sel_b_o     (sel_b),
        .busy_o      (busy),
        .done_o      (done),
        .response_o  (response)
    );

    // Counter array stand-in: presents the counts for each evaluation from its clear onward.
    always @(posedge clk) begin
        #1;
        if (cnt_clr === 1'b1) begin
            if (ev < MaxEval) begin
                cnt_a        = va[ev];
                cnt_b        = vb[ev];
                sel_log_a[ev] = sel_a;
                sel_log_b[ev] = sel_b;
            end
            ev++;
        end else if (ev >= 1 && ev <= MaxEval && ro_en === 1'b1) begin
            ro_cnt[ev-1]++;
            if (sel_a !== sel_log_a[ev-1] || sel_b !== sel_log_b[ev-1]) unstable++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int model_step(input int s);
        int fb;
        fb = ((s >> 7) ^ (s >> 5) ^ (s >> 4) ^ (s >> 3)) & 1;
        return ((s << 1) | fb) & 255;
    endfunction

    function automatic void model_pair(input int s, output int a, output int b);
        a = s % (1 << SelW);
        b = (s >> SelW) % (1 << SelW);
        if (a == b) b = a ^ 1;
    endfunction

    function automatic int model_resp();
        int r;
        int votes;
        r = 0;
        for (int i = 0; i < RespBits; i++) begin
            votes = 0;
            for (int p = 0; p < Passes; p++) begin
                if (va[i*Passes+p] > vb[i*Passes+p]) votes++;
            end
            if (2 * votes > Passes) r |= (1 << i);
        end
        return r;
    endfunction

    task automatic fill_pattern(input int pat);
        int i;
        for (int e = 0; e < MaxEval; e++) begin
            i = e / Passes;
            case (pat)
                0: begin
                    va[e] = (i < 4) ? 16'h0100 : 16'h0200;
                    vb[e] = (i < 4) ? 16'h00FF : 16'h0200;
                end
                1: begin va[e] = 16'h0005; vb[e] = 16'h0010; end
                2: begin va[e] = 16'hFFFF; vb[e] = 16'h0000; end
                default: begin
                    va[e] = (i % 2 == 0) ? 16'h0300 : 16'h0001;
                    vb[e] = 16'h0002;
                end
            endcase
        end
    endtask

    // Latency is counted in clock edges from the cycle in which start is driven high.
    task automatic do_run(input string tag, input logic [7:0] ch, input int win,
                          input int exp_lat, input int exp_resp, input bit poke);
        int lat, busy_bad, bad_sel, bad_ro, wexp, s, ma, mb;
        ev       = 0;
        unstable = 0;
        for (int e = 0; e < MaxEval; e++) ro_cnt[e] = 0;
        @(posedge clk); #1;
        challenge  = ch;
        window_len = WinW'(win);
        start      = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        lat      = 1;
        busy_bad = 0;
        while (done !== 1'b1 && lat < LatLimit) begin
            if (busy !== 1'b1) busy_bad++;
            if (poke && lat == 20) begin
                start = 1'b1; challenge = ~ch; window_len = '0;
            end else if (poke && lat == 21) begin
                start = 1'b0; challenge = ch; window_len = WinW'(win);
            end
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ".latency"}, lat, exp_lat);
        check({tag, ".busy_during_run"}, busy_bad, 0);
        check({tag, ".busy_at_done"}, busy, 1);
        check({tag, ".response"}, response, exp_resp);
        @(posedge clk); #1;
        check({tag, ".done_one_cycle"}, done, 0);
        check({tag, ".busy_after_done"}, busy, 0);
        check({tag, ".evaluations"}, ev, MaxEval);
        s       = (ch == 8'h00) ? 1 : int'(ch);
        bad_sel = 0;
        for (int i = 0; i < RespBits; i++) begin
            model_pair(s, ma, mb);
            for (int p = 0; p < Passes; p++) begin
                if (sel_log_a[i*Passes+p] !== SelW'(ma) || sel_log_b[i*Passes+p] !== SelW'(mb))
                    bad_sel++;
            end
            s = model_step(s);
        end
        check({tag, ".pair_sequence"}, bad_sel, 0);
        wexp   = (win == 0) ? 1 : win;
        bad_ro = 0;
        for (int e = 0; e < MaxEval; e++) if (ro_cnt[e] != wexp) bad_ro++;
        check({tag, ".run_window"}, bad_ro, 0);
        check({tag, ".sel_stable"}, unstable, 0);
    endtask

    initial begin
        int  found;
        int  win;
        logic [7:0] ch;

        vecs[0] = '{8'h5A, 10, 0, 'h0F, RespBits*Passes*(10+Settle+2)+1, 'hA, 'h5, 1'b0};
        vecs[1] = '{8'h00,  3, 2, 'hFF, RespBits*Passes*(3+Settle+2)+1,  'h1, 'h0, 1'b0};
        vecs[2] = '{8'h11,  0, 3, 'h55, RespBits*Passes*(1+Settle+2)+1,  'h1, 'h0, 1'b0};
        vecs[3] = '{8'hC3,  1, 1, 'h00, RespBits*Passes*(1+Settle+2)+1,  'h3, 'hC, 1'b0};
        vecs[4] = '{8'h77,  2, 0, 'h0F, RespBits*Passes*(2+Settle+2)+1,  'h7, 'h6, 1'b1};

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset.ro_en", ro_en, 0);
        check("reset.cnt_clr", cnt_clr, 0);
        check("reset.sel_a", sel_a, 0);
        check("reset.sel_b", sel_b, 0);
        check("reset.busy", busy, 0);
        check("reset.done", done, 0);
        check("reset.response", response, 0);
        rst = 1'b0;

        // Directed vector table
        for (int v = 0; v < 5; v++) begin
            fill_pattern(vecs[v].pat);
            do_run($sformatf("vec%0d", v), vecs[v].ch, vecs[v].win, vecs[v].exp_lat,
                   vecs[v].exp_resp, vecs[v].poke);
            check($sformatf("vec%0d.first_sel_a", v), sel_log_a[0], vecs[v].a0);
            check($sformatf("vec%0d.first_sel_b", v), sel_log_b[0], vecs[v].b0);
        end

`ifdef RO_PUF_MAJ_VOTE_EN
        // Majority: passes 1,0,1 give 1 and passes 0,0,1 give 0.
        fill_pattern(3);
        va[0] = 16'd9; vb[0] = 16'd1;
        va[1] = 16'd1; vb[1] = 16'd9;
        va[2] = 16'd9; vb[2] = 16'd1;
        va[3] = 16'd1; vb[3] = 16'd9;
        va[4] = 16'd1; vb[4] = 16'd9;
        va[5] = 16'd9; vb[5] = 16'd1;
        do_run("vote", 8'h2B, 2, RespBits*Passes*(2+Settle+2)+1, model_resp(), 1'b0);
        check("vote.bit0_101", response[0], 1);
        check("vote.bit1_001", response[1], 0);
`endif

        // Random challenges, windows and counts against the reference model
        for (int r = 0; r < 6; r++) begin
            ch  = 8'($urandom);
            win = $urandom_range(0, 12);
            for (int e = 0; e < MaxEval; e++) begin
                va[e] = 16'($urandom);
                vb[e] = ($urandom_range(0, 3) == 0) ? va[e] : 16'($urandom);
            end
            do_run($sformatf("rand%0d", r), ch, win,
                   RespBits*Passes*(((win == 0) ? 1 : win)+Settle+2)+1, model_resp(), 1'b0);
        end

        // Abort during RUN of bit 3, then a clean run
        fill_pattern(2);
        do_run("pre_abort", 8'h3C, 4, RespBits*Passes*(4+Settle+2)+1, 'hFF, 1'b0);
        fill_pattern(0);
        ev = 0;
        @(posedge clk); #1;
        challenge  = 8'h3C;
        window_len = WinW'(5);
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        found = 0;
        for (int n = 0; n < LatLimit && found == 0; n++) begin
            if (ev == 3 * Passes + 1 && ro_en === 1'b1) found = 1;
            else begin
                @(posedge clk); #1;
            end
        end
        check("abort.reached_bit3_run", found, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort.ro_en", ro_en, 0);
        check("abort.response", response, 0);
        check("abort.busy", busy, 0);
        check("abort.done", done, 0);
        check("abort.sel_a", sel_a, 0);
        rst = 1'b0;
        fill_pattern(0);
        do_run("post_abort", 8'h5A, 10, RespBits*Passes*(10+Settle+2)+1, 'h0F, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
